// File: rtl/data_bus_pkg.sv
// Shared constants for the data-bus responder.
// Holds the MMIO map, STATUS bit layout and region-select rule.
package data_bus_pkg;

  localparam logic [3:0] OFF_OUT_DATA = 4'h0;
  localparam logic [3:0] OFF_STATUS   = 4'h1;
  localparam logic [3:0] OFF_CYCLE    = 4'h2;
  localparam logic [3:0] OFF_HALT     = 4'h3;
  localparam logic [3:0] OFF_SCRATCH  = 4'h4;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_HALTED    = 2;
  localparam int ST_OVERFLOW  = 3;
  localparam int ST_COUNT_LSB = 8;

  function automatic logic is_mmio(
    input logic [31:0] addr,
    input int          aw
  );
    return addr[aw-1];
  endfunction

endpackage

// File: rtl/data_bus_responder_if.sv
// Core data port plus output-FIFO drain port.
// master = core/bench side, slave = responder.
interface data_bus_responder_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int SIZE       = 32
);

  logic [ADDR_WIDTH-1:0] daddr;
  logic                  d_rw;
  logic [SIZE-1:0]       ddata_w;
  logic [SIZE-1:0]       ddata_r;
  logic [SIZE-1:0]       out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  halted;
  logic                  overflow;

  modport master (
    output daddr, d_rw, ddata_w, out_ready,
    input  ddata_r, out_data, out_valid,
    input  halted, overflow
  );

  modport slave (
    input  daddr, d_rw, ddata_w, out_ready,
    output ddata_r, out_data, out_valid,
    output halted, overflow
  );

endinterface

// File: rtl/data_bus_responder_out_fifo.sv
// Registered output FIFO, no fall-through.
// A push while full is dropped unless a pop frees the slot.
module out_fifo #(
  parameter int SIZE       = 32,
  parameter int FIFO_DEPTH = 8,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int CW = AW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [SIZE-1:0] wdata,
  input  logic            ready,
  output logic [SIZE-1:0] head,
  output logic            valid,
  output logic            full,
  output logic            empty,
  output logic [CW-1:0]   count,
  output logic            drop
);

  logic [SIZE-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            pop;
  logic            push_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(FIFO_DEPTH));
  assign valid   = !empty;
  assign head    = mem[rd_ptr];
  assign pop     = valid & ready;
  assign push_ok = push & (!full | pop);
  assign drop    = push & full & !pop;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop);
    end
  end

endmodule

// File: rtl/data_bus_responder.sv
// Data-bus target for the single-cycle core: RAM below the
// region bit, MMIO (FIFO, cycle counter, scratch, halt) above.
module data_bus_responder
  import data_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int SIZE       = 32,
  parameter int FIFO_DEPTH = 8
) (
  input logic CLK,
  input logic RESET,
  data_bus_responder_if.slave bus
);

  localparam int RW = ADDR_WIDTH - 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [SIZE-1:0] ram [2**RW];
  logic [SIZE-1:0] cycle;
  logic [SIZE-1:0] scratch;
  logic [SIZE-1:0] status;
  logic [SIZE-1:0] rdata;
  logic [CW-1:0]   count;
  logic [3:0]      off;
  logic            mmio;
  logic            wr_mmio;
  logic            full;
  logic            empty;
  logic            drop;

  assign mmio    = is_mmio(32'(bus.daddr), ADDR_WIDTH);
  assign off     = bus.daddr[3:0];
  assign wr_mmio = bus.d_rw & mmio;

  out_fifo #(
    .SIZE       (SIZE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RESET),
    .push  (wr_mmio && off == OFF_OUT_DATA),
    .wdata (bus.ddata_w),
    .ready (bus.out_ready),
    .head  (bus.out_data),
    .valid (bus.out_valid),
    .full  (full),
    .empty (empty),
    .count (count),
    .drop  (drop)
  );

  // RAM is deliberately outside reset so a mid-run reset keeps program data
  always_ff @(posedge CLK) begin
    if (bus.d_rw && !mmio) ram[bus.daddr[RW-1:0]] <= bus.ddata_w;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cycle        <= '0;
      scratch      <= '0;
      bus.halted   <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      if (wr_mmio && off == OFF_CYCLE) cycle <= bus.ddata_w;
      else if (!bus.halted)            cycle <= cycle + 1'b1;
      if (wr_mmio && off == OFF_HALT)    bus.halted <= 1'b1;
      if (wr_mmio && off == OFF_SCRATCH) scratch    <= bus.ddata_w;
      if (drop) bus.overflow <= 1'b1;
    end
  end

  always_comb begin
    status = '0;
    status[ST_EMPTY]    = empty;
    status[ST_FULL]     = full;
    status[ST_HALTED]   = bus.halted;
    status[ST_OVERFLOW] = bus.overflow;
    status[ST_COUNT_LSB +: CW] = count;
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      !mmio:                         rdata = ram[bus.daddr[RW-1:0]];
      mmio && off == OFF_OUT_DATA:   rdata = SIZE'(count);
      mmio && off == OFF_STATUS:     rdata = status;
      mmio && off == OFF_CYCLE:      rdata = cycle;
      mmio && off == OFF_HALT:       rdata = SIZE'(bus.halted);
      mmio && off == OFF_SCRATCH:    rdata = scratch;
      default:                       rdata = '0;
    endcase
  end

  assign bus.ddata_r = rdata;

endmodule

// File: tb/tb_data_bus_responder.sv
// Directed + random bench for data_bus_responder against a
// queue-based model of the RAM/MMIO/FIFO behaviour.
module tb_data_bus_responder;
  import data_bus_pkg::*;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_bus_responder_if #(.ADDR_WIDTH(10), .SIZE(32)) bus ();

  data_bus_responder #(
    .ADDR_WIDTH (10),
    .SIZE       (32),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] q [$];
  logic [31:0] m_ram [int];
  logic [31:0] m_cyc;
  logic [31:0] m_scr;
  bit          m_halt;
  bit          m_ovf;

  function automatic logic [9:0] mm(input logic [3:0] off);
    return {6'b100000, off};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [9:0] a);
    int n = q.size();
    if (!a[9]) return m_ram[int'(a[8:0])];
    case (a[3:0])
      OFF_OUT_DATA: return 32'(n);
      OFF_STATUS:   return {16'b0, 8'(n), 4'b0, m_ovf, m_halt,
                            n == DEPTH, n == 0};
      OFF_CYCLE:    return m_cyc;
      OFF_HALT:     return {31'b0, m_halt};
      OFF_SCRATCH:  return m_scr;
      default:      return 32'h0;
    endcase
  endfunction

  task automatic observe(string tag);
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'(q.size() != 0));
    if (q.size() != 0) chk({tag, ".head"}, bus.out_data, q[0]);
    chk({tag, ".halted"}, 32'(bus.halted), 32'(m_halt));
    chk({tag, ".ovf"}, 32'(bus.overflow), 32'(m_ovf));
    if (!bus.d_rw && (bus.daddr[9] || m_ram.exists(int'(bus.daddr[8:0]))))
      chk({tag, ".rd"}, bus.ddata_r, exp_rd(bus.daddr));
  endtask

  task automatic model_edge();
    bit m    = bus.daddr[9];
    bit w    = bus.d_rw;
    int off  = int'(bus.daddr[3:0]);
    bit full = q.size() == DEPTH;
    bit pop  = q.size() != 0 && bus.out_ready;
    bit push = w && m && off == 0;
    if (w && !m) m_ram[int'(bus.daddr[8:0])] = bus.ddata_w;
    if (rst) begin
      q.delete();
      m_cyc = 0; m_scr = 0; m_halt = 0; m_ovf = 0;
      return;
    end
    if (pop) void'(q.pop_front());
    if (push) begin
      if (full && !pop) m_ovf = 1;
      else q.push_back(bus.ddata_w);
    end
    if (w && m && off == 2) m_cyc = bus.ddata_w;
    else if (!m_halt) m_cyc = m_cyc + 1;
    if (w && m && off == 3) m_halt = 1;
    if (w && m && off == 4) m_scr = bus.ddata_w;
  endtask

  task automatic cycle(string tag, logic [9:0] a, bit w,
                       logic [31:0] d, bit rdy, bit r = 0);
    rst = r;
    bus.daddr = a; bus.d_rw = w; bus.ddata_w = d; bus.out_ready = rdy;
    #1;
    observe(tag);
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(string tag, logic [9:0] a, bit rdy, logic [31:0] exp);
    rst = 0;
    bus.daddr = a; bus.d_rw = 0; bus.ddata_w = 0; bus.out_ready = rdy;
    #1;
    chk(tag, bus.ddata_r, exp);
    observe(tag);
    model_edge();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] fib [8] = '{0, 1, 1, 2, 3, 5, 8, 13};
  logic [31:0] t4   [8] = '{101, 102, 103, 104, 105, 106, 107, 99};

  initial begin
    rst = 1;
    bus.daddr = '0; bus.d_rw = 0; bus.ddata_w = '0; bus.out_ready = 0;
    @(posedge clk);
    #1;
    q.delete();
    m_cyc = 0; m_scr = 0; m_halt = 0; m_ovf = 0;
    cycle("rst", mm(1), 0, 0, 0, 1);

    rd("t1_status", mm(1), 0, 32'h1);
    repeat (4) cycle("t1_idle", mm(5), 0, 0, 0);
    rd("t1_cycle", mm(2), 0, 32'd5);
    rd("t1_halt", mm(3), 0, 32'h0);

    cycle("t2_w", 10'h005, 1, 32'hDEADBEEF, 0);
    rd("t2_r", 10'h005, 0, 32'hDEADBEEF);
    rd("t2_alias", 10'h205, 0, 32'h0);

    for (int i = 0; i < 8; i++) cycle("t3_push", mm(0), 1, fib[i], 0);
    rd("t3_full", mm(1), 0, 32'h802);
    cycle("t3_push9", mm(0), 1, 32'd21, 0);
    rd("t3_ovf", mm(1), 0, 32'h80A);
    for (int i = 0; i < 8; i++) begin
      chk("t3_order", bus.out_data, fib[i]);
      cycle("t3_drain", mm(1), 0, 0, 1);
    end
    rd("t3_after", mm(1), 0, 32'h9);

    cycle("t4_rst", mm(1), 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) cycle("t4_fill", mm(0), 1, 100 + i, 0);
    cycle("t4_pp", mm(0), 1, 32'd99, 1);
    rd("t4_cnt", mm(1), 0, 32'h802);
    for (int i = 0; i < 8; i++) begin
      chk("t4_order", bus.out_data, t4[i]);
      cycle("t4_drain", mm(1), 0, 0, 1);
    end
    cycle("t4_p1", mm(0), 1, 32'd7, 0);
    cycle("t4_pp1", mm(0), 1, 32'd8, 1);
    chk("t4_valid1", 32'(bus.out_valid), 32'h1);
    chk("t4_head1", bus.out_data, 32'd8);
    cycle("t4_dr1", mm(1), 0, 0, 1);

    cycle("t5_rst", mm(1), 0, 0, 0, 1);
    cycle("t5_ld", mm(2), 1, 32'hFFFFFFFF, 0);
    rd("t5_max", mm(2), 0, 32'hFFFFFFFF);
    rd("t5_wrap", mm(2), 0, 32'h0);
    cycle("t5_ld39", mm(2), 1, 32'd39, 0);
    rd("t5_39", mm(2), 0, 32'd39);
    cycle("t5_halt", mm(3), 1, 32'h0, 0);
    for (int i = 0; i < 10; i++) rd("t5_frozen", mm(2), 0, 32'd41);
    chk("t5_halted", 32'(bus.halted), 32'h1);
    cycle("t5_scr", mm(4), 1, 32'hA5A5_0F0F, 0);
    rd("t5_scr_rd", mm(4), 0, 32'hA5A5_0F0F);

    cycle("t6_rst", mm(1), 0, 0, 0, 1);
    cycle("t6_ram", 10'h010, 1, 32'h12345678, 0);
    for (int i = 0; i < 3; i++) cycle("t6_push", mm(0), 1, 200 + i, 0);
    cycle("t6_mid", mm(1), 0, 0, 1, 1);
    chk("t6_valid", 32'(bus.out_valid), 32'h0);
    rd("t6_status", mm(1), 0, 32'h1);
    rd("t6_ramkeep", 10'h010, 0, 32'h12345678);

    for (int i = 0; i < 16; i++)
      cycle("rnd_init", 10'(i), 1, $urandom, 0);
    for (int i = 0; i < 400; i++) begin
      logic [9:0] a;
      if ($urandom_range(0, 1) == 1)
        a = {1'b1, 5'($urandom), 4'($urandom_range(0, 7))};
      else
        a = 10'($urandom_range(0, 15));
      cycle("rnd", a, 1'($urandom_range(0, 1)), $urandom,
            1'($urandom_range(0, 1)), $urandom_range(0, 49) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
